bus_sequencer: RTL and testbench

- Parametrised control sequencer for the shared-bus register/ALU datapath: NREG general registers, input-switch buffer, immediate buffer, operand register A, ALU, result register Z.
- Accepts one instruction per start/done handshake and steps it through a Moore state machine.
- Emits one-hot tristate-buffer enables, register load enables and ALU operation code each cycle.
- Generational successor of the fixed 4-to-8 control decoder: holds its own state, supports any register count, and reports illegal register selects.

---
 rtl/bus_sequencer_if.sv | 35 +++
 rtl/bus_sequencer.sv | 150 +++++++++++++++
 tb/tb_bus_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_sequencer_if.sv
// Handshake and control-bus signals of the shared-bus register/ALU sequencer.
// start is accepted on a rising edge only while the sequencer is idle or in its done cycle; done pulses one cycle.
interface bus_sequencer_if #(
  parameter int NREG = 4,
  parameter int SELW = 2
);
  logic            start;
  logic [2:0]      op;
  logic [SELW-1:0] rd;
  logic [SELW-1:0] rs;
  logic [NREG-1:0] reg_buf_en;
  logic [NREG-1:0] reg_ld;
  logic            sw_buf_en;
  logic            imm_buf_en;
  logic            a_ld;
  logic            z_ld;
  logic            z_buf_en;
  logic [1:0]      alu_op;
  logic            busy;
  logic            done;
  logic            err;
  logic [2:0]      dbg_state;

  modport master (
    output start, op, rd, rs,
    input  reg_buf_en, reg_ld, sw_buf_en, imm_buf_en, a_ld, z_ld, z_buf_en,
    input  alu_op, busy, done, err, dbg_state
  );

  modport slave (
    input  start, op, rd, rs,
    output reg_buf_en, reg_ld, sw_buf_en, imm_buf_en, a_ld, z_ld, z_buf_en,
    output alu_op, busy, done, err, dbg_state
  );
endinterface

// File: rtl/bus_sequencer.sv
// Moore control sequencer for a shared-bus register file / ALU datapath.
// One instruction per start/done handshake; all outputs decode from registered state and latched fields.
module bus_sequencer #(
  parameter int NREG = 4,
  parameter int SELW = 2
) (
  input  logic            Clock,
  input  logic            Resetn,
  bus_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XFER = 3'd1,
    S_OPA  = 3'd2,
    S_OPB  = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [SELW:0] NREG_L = (SELW+1)'(NREG);
  localparam logic [2:0]    OP_MOV  = 3'd2;
  localparam logic [2:0]    OP_OR   = 3'd6;
  localparam logic [2:0]    OP_ADDI = 3'd7;

  state_t          state, state_nx;
  logic [2:0]      op_q;
  logic [SELW-1:0] rd_q, rs_q;
  logic            err_q;
  logic            accept, uses_rs, illegal;

  // rs only matters for the register-to-register ops MOV..OR.
  assign uses_rs = (bus.op >= OP_MOV) && (bus.op <= OP_OR);
  assign illegal = ({1'b0, bus.rd} >= NREG_L) || (uses_rs && ({1'b0, bus.rs} >= NREG_L));
  assign accept  = bus.start && (state == S_IDLE || state == S_DONE);

  function automatic logic [NREG-1:0] onehot(input logic [SELW-1:0] sel);
    logic [NREG-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel == SELW'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.op;
      rd_q  <= bus.rd;
      rs_q  <= bus.rs;
      err_q <= illegal;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (!bus.start)          state_nx = S_IDLE;
        else if (illegal)        state_nx = S_DONE;
        else if (bus.op <= OP_MOV) state_nx = S_XFER;
        else                     state_nx = S_OPA;
      end
      S_XFER:  state_nx = S_DONE;
      S_OPA:   state_nx = S_OPB;
      S_OPB:   state_nx = S_WB;
      S_WB:    state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  logic [NREG-1:0] reg_buf_en, reg_ld;
  logic            sw_buf_en, imm_buf_en, a_ld, z_ld, z_buf_en, busy, done, err;
  logic [1:0]      alu_op;

  always_comb begin
    reg_buf_en = '0;
    reg_ld     = '0;
    sw_buf_en  = 1'b0;
    imm_buf_en = 1'b0;
    a_ld       = 1'b0;
    z_ld       = 1'b0;
    z_buf_en   = 1'b0;
    alu_op     = 2'b00;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_XFER: begin
        busy = 1'b1;
        case (op_q)
          3'd0:    sw_buf_en  = 1'b1;
          3'd1:    imm_buf_en = 1'b1;
          default: reg_buf_en = onehot(rs_q);
        endcase
        reg_ld = onehot(rd_q);
      end
      S_OPA: begin
        busy       = 1'b1;
        reg_buf_en = onehot(rd_q);
        a_ld       = 1'b1;
      end
      S_OPB: begin
        busy = 1'b1;
        z_ld = 1'b1;
        if (op_q == OP_ADDI) begin
          imm_buf_en = 1'b1;
        end else begin
          reg_buf_en = onehot(rs_q);
          // ADD..OR (011..110) map onto ALU codes 00..11.
          alu_op     = 2'(op_q - 3'd3);
        end
      end
      S_WB: begin
        busy     = 1'b1;
        z_buf_en = 1'b1;
        reg_ld   = onehot(rd_q);
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign bus.reg_buf_en = reg_buf_en;
  assign bus.reg_ld     = reg_ld;
  assign bus.sw_buf_en  = sw_buf_en;
  assign bus.imm_buf_en = imm_buf_en;
  assign bus.a_ld       = a_ld;
  assign bus.z_ld       = z_ld;
  assign bus.z_buf_en   = z_buf_en;
  assign bus.alu_op     = alu_op;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: a 4-register and a 3-register instance share clock and reset.
// Expected output vectors are stamped with the cycle they must appear in.
module tb_bus_sequencer;
  localparam int W = 34;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_sequencer_if #(.NREG(4), .SELW(2)) bus4 ();
  bus_sequencer_if #(.NREG(3), .SELW(2)) bus3 ();

  bus_sequencer #(.NREG(4), .SELW(2)) dut4 (.Clock(clk), .Resetn(rst_n), .bus(bus4.slave));
  bus_sequencer #(.NREG(3), .SELW(2)) dut3 (.Clock(clk), .Resetn(rst_n), .bus(bus3.slave));

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // {reg_buf_en[3:0], reg_ld[3:0], sw, imm, a_ld, z_ld, z_buf, alu_op[1:0], busy, done, err}
  logic [17:0] o4, o3;
  assign o4 = {bus4.reg_buf_en, bus4.reg_ld, bus4.sw_buf_en, bus4.imm_buf_en, bus4.a_ld,
               bus4.z_ld, bus4.z_buf_en, bus4.alu_op, bus4.busy, bus4.done, bus4.err};
  assign o3 = {1'b0, bus3.reg_buf_en, 1'b0, bus3.reg_ld, bus3.sw_buf_en, bus3.imm_buf_en,
               bus3.a_ld, bus3.z_ld, bus3.z_buf_en, bus3.alu_op, bus3.busy, bus3.done, bus3.err};

  function automatic logic [17:0] mk(input logic [3:0] rbe, input logic [3:0] rld,
                                     input logic sw, input logic imm, input logic a,
                                     input logic z, input logic zb, input logic [1:0] alu,
                                     input logic bsy, input logic dn, input logic er);
    return {rbe, rld, sw, imm, a, z, zb, alu, bsy, dn, er};
  endfunction

  function automatic logic [3:0] oh(input int sel);
    logic [3:0] r;
    r = 4'b0001;
    return r << sel;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d out=%05h, expected cyc=%0d out=%05h",
               name, got[33:18], got[17:0], exp[33:18], exp[17:0]);
    end
  endtask

  // Expected per-cycle outputs of one instruction, derived from the op table.
  task automatic push_model(input int which, input int c, input logic [2:0] op,
                            input int rd, input int rs, output int len);
    int nreg;
    bit ill;
    logic [1:0] alu;
    logic [17:0] v[$];
    nreg = (which == 3) ? 3 : 4;
    ill  = (rd >= nreg) || (op >= 3'd2 && op <= 3'd6 && rs >= nreg);
    if (ill) begin
      v.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1));
    end else if (op <= 3'd2) begin
      v.push_back(mk((op == 3'd2) ? oh(rs) : 4'h0, oh(rd), op == 3'd0, op == 3'd1,
                     0, 0, 0, 2'b00, 1, 0, 0));
      v.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    end else begin
      case (op)
        3'd4:    alu = 2'b01;
        3'd5:    alu = 2'b10;
        3'd6:    alu = 2'b11;
        default: alu = 2'b00;
      endcase
      v.push_back(mk(oh(rd), 4'h0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0));
      v.push_back(mk((op == 3'd7) ? 4'h0 : oh(rs), 4'h0, 0, op == 3'd7, 0, 1, 0, alu, 1, 0, 0));
      v.push_back(mk(4'h0, oh(rd), 0, 0, 0, 0, 1, 2'b00, 1, 0, 0));
      v.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    end
    len = v.size();
    for (int i = 0; i < len; i++) begin
      if (which == 3) exp3_q.push_back({16'(c + 1 + i), v[i]});
      else            exp_q.push_back({16'(c + 1 + i), v[i]});
    end
  endtask

  task automatic drive(input int which, input logic s, input logic [2:0] op,
                       input logic [1:0] rd, input logic [1:0] rs);
    if (which == 3) begin
      bus3.start = s; bus3.op = op; bus3.rd = rd; bus3.rs = rs;
      bus4.start = 1'b0;
    end else begin
      bus4.start = s; bus4.op = op; bus4.rd = rd; bus4.rs = rs;
      bus3.start = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle with start left as driven.
  task automatic send(input int which, input logic [2:0] op, input int rd, input int rs,
                      input bit garble);
    int len;
    drive(which, 1'b1, op, 2'(rd), 2'(rs));
    push_model(which, cyc, op, rd, rs, len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (garble && i < len - 1)
        drive(which, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic idle(input int n);
    bus4.start = 1'b0;
    bus3.start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if ($countones({bus4.reg_buf_en, bus4.sw_buf_en, bus4.imm_buf_en, bus4.z_buf_en}) > 1 ||
          $countones({bus3.reg_buf_en, bus3.sw_buf_en, bus3.imm_buf_en, bus3.z_buf_en}) > 1) begin
        n_fail++;
        $display("FAIL bus_exclusive: cyc=%0d dut4=%05h dut3=%05h, at most one driver required",
                 cyc, o4, o3);
      end
      if (o4 != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dut4_unexpected: cyc=%0d out=%05h, expected all zero", cyc, o4);
        end else check("dut4_seq", {cyc[15:0], o4}, exp_q.pop_front());
      end
      if (o3 != '0) begin
        if (exp3_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dut3_unexpected: cyc=%0d out=%05h, expected all zero", cyc, o3);
        end else check("dut3_seq", {cyc[15:0], o3}, exp3_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    drive(4, 1'b0, 3'd0, 2'd0, 2'd0);
    drive(3, 1'b0, 3'd0, 2'd0, 2'd0);
    #12;
    check("reset_out4", {16'd0, o4}, '0);
    check("reset_out3", {16'd0, o3}, '0);
    check("reset_state", W'(bus4.dbg_state), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD r2, then ADD r1,r3
    send(4, 3'd0, 2, 0, 0);
    idle(2);
    send(4, 3'd3, 1, 3, 0);
    idle(1);

    // SUB r0,r1 back-to-back with ADDI r0 (start held through DONE)
    send(4, 3'd4, 0, 1, 0);
    send(4, 3'd7, 0, 0, 0);
    idle(2);

    // NREG=3: illegal rs, legal LOAD with ignored rs=3, illegal rd
    send(3, 3'd2, 1, 3, 0);
    idle(1);
    send(3, 3'd0, 2, 3, 0);
    send(3, 3'd7, 3, 0, 0);
    idle(2);

    // OR r2,r1 aborted by reset during OPB
    c = cyc;
    drive(4, 1'b1, 3'd6, 2'd2, 2'd1);
    exp_q.push_back({16'(c + 1), mk(4'b0100, 4'h0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0)});
    exp_q.push_back({16'(c + 2), mk(4'b0010, 4'h0, 0, 0, 0, 1, 0, 2'b11, 1, 0, 0)});
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {16'd0, o4}, '0);
    check("abort_state", W'(bus4.dbg_state), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4, 3'd1, 0, 0, 0);
    idle(2);

    // Random ops on both instances, inputs scrambled while busy
    for (int k = 0; k < 40; k++) begin
      send(($urandom_range(0, 3) == 0) ? 3 : 4, 3'($urandom_range(0, 7)),
           $urandom_range(0, 3), $urandom_range(0, 3), 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(4);

    n_checks++;
    if (exp_q.size() != 0 || exp3_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expected vectors never appeared, 0 required",
               exp_q.size(), exp3_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
